// File: rtl/fnd_scan6.sv
// Six-digit multiplexed 7-segment scanner for an HH:MM:SS display.
// Digits are enabled one at a time for SCAN_DIV clocks each; the time
// fields are captured once per frame so a digit never shows a value
// from a different frame than its neighbour.
module fnd_scan6 #(
   parameter logic [31:0] SCAN_DIV = 32'd50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic [5:0] hour,
   output logic [6:0] seg,
   output logic [5:0] com
);

   localparam logic [6:0] SEG_DASH = 7'h40;

   logic [31:0] cnt;
   logic [2:0]  idx;
   logic [5:0]  snap_sec;
   logic [5:0]  snap_min;
   logic [5:0]  snap_hour;

   logic        frame_start;
   logic        dwell_end;
   logic [5:0]  src_sec;
   logic [5:0]  src_min;
   logic [5:0]  src_hour;
   logic [5:0]  field;
   logic [5:0]  digit;
   logic        want_tens;
   logic [6:0]  seg_next;
   logic [5:0]  com_next;

   function automatic logic [6:0] seg7(input logic [5:0] d);
      logic [6:0] s;
      case (d)
         6'd0:    s = 7'h3F;
         6'd1:    s = 7'h06;
         6'd2:    s = 7'h5B;
         6'd3:    s = 7'h4F;
         6'd4:    s = 7'h66;
         6'd5:    s = 7'h6D;
         6'd6:    s = 7'h7D;
         6'd7:    s = 7'h07;
         6'd8:    s = 7'h7F;
         6'd9:    s = 7'h6F;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   assign frame_start = (cnt == 32'd0) && (idx == 3'd0);
   assign dwell_end   = (cnt == SCAN_DIV - 32'd1);

   // On the frame-start edge the snapshot is being loaded from the inputs,
   // so the first digit of the frame must already use the incoming values.
   assign src_sec  = frame_start ? sec  : snap_sec;
   assign src_min  = frame_start ? min  : snap_min;
   assign src_hour = frame_start ? hour : snap_hour;

   // Pick the field and digit position for the current index, then encode.
   always_comb begin
      field     = src_sec;
      want_tens = idx[0];
      case (idx)
         3'd0, 3'd1: field = src_sec;
         3'd2, 3'd3: field = src_min;
         3'd4, 3'd5: field = src_hour;
         default:    field = src_sec;
      endcase
      digit    = want_tens ? (field / 6'd10) : (field % 6'd10);
      seg_next = (field >= 6'd60) ? SEG_DASH : seg7(digit);
      com_next = 6'd1 << idx;
   end

   // Dwell counter, digit index, frame snapshot and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= 32'd0;
         idx       <= 3'd0;
         snap_sec  <= 6'd0;
         snap_min  <= 6'd0;
         snap_hour <= 6'd0;
         seg       <= 7'h00;
         com       <= 6'b000000;
      end else begin
         if (dwell_end) begin
            cnt <= 32'd0;
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
         end else begin
            cnt <= cnt + 32'd1;
         end
         if (frame_start) begin
            snap_sec  <= sec;
            snap_min  <= min;
            snap_hour <= hour;
         end
         seg <= seg_next;
         com <= com_next;
      end
   end

endmodule

// File: tb/tb_fnd_scan6.sv
// Directed bench for fnd_scan6 with SCAN_DIV = 4 (24-cycle frame).
module tb_fnd_scan6;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] sec = 6'd0;
   logic [5:0] min = 6'd0;
   logic [5:0] hour = 6'd0;
   logic [6:0] seg;
   logic [5:0] com;

   int n_checks = 0;
   int n_errors = 0;
   int k = 0;

   typedef struct {
      logic [5:0]  s;
      logic [5:0]  m;
      logic [5:0]  h;
      logic [41:0] exp_seg;   // {d5,d4,d3,d2,d1,d0}
   } vec_t;

   vec_t vecs[5];

   fnd_scan6 #(.SCAN_DIV(32'd4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .sec  (sec),
      .min  (min),
      .hour (hour),
      .seg  (seg),
      .com  (com)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s (edge %0d): got %0h expected %0h", name, k, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   // Check n edges of steady scanning; k counts edges since reset release.
   task automatic check_span(input int n, input logic [41:0] e);
      int d;
      logic [6:0] es;
      for (int i = 0; i < n; i++) begin
         tick();
         d  = ((k - 1) / DIV) % 6;
         es = e[d*7 +: 7];
         chk("com", int'(com), int'(6'd1 << d));
         chk("seg", int'(seg), int'(es));
      end
   endtask

   // Hold reset for three edges with the given inputs, then release.
   task automatic do_reset(input logic [5:0] s, input logic [5:0] m, input logic [5:0] h);
      @(negedge clk);
      rst_n = 1'b0;
      sec = s; min = m; hour = h;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_com", int'(com), 0);
         chk("reset_seg", int'(seg), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
   endtask

   initial begin
      int first_edge;
      int second_edge;
      logic [5:0] prev_com;

      vecs[0] = '{6'd37, 6'd12, 6'd9,  {7'h3F, 7'h6F, 7'h06, 7'h5B, 7'h4F, 7'h07}};
      vecs[1] = '{6'd0,  6'd59, 6'd0,  {7'h3F, 7'h3F, 7'h6D, 7'h6F, 7'h3F, 7'h3F}};
      vecs[2] = '{6'd37, 6'd60, 6'd63, {7'h40, 7'h40, 7'h40, 7'h40, 7'h4F, 7'h07}};
      vecs[3] = '{6'd59, 6'd0,  6'd5,  {7'h3F, 7'h6D, 7'h3F, 7'h3F, 7'h6D, 7'h6F}};
      vecs[4] = '{6'd8,  6'd23, 6'd23, {7'h5B, 7'h4F, 7'h5B, 7'h4F, 7'h3F, 7'h7F}};

      // Table: one full frame per vector after a reset, from the second edge on.
      for (int v = 0; v < 5; v++) begin
         do_reset(vecs[v].s, vecs[v].m, vecs[v].h);
         tick();
         check_span(23, vecs[v].exp_seg);
         check_span(24, vecs[v].exp_seg);
      end

      // No tearing: sec changes while digit 1 is active.
      do_reset(6'd37, 6'd12, 6'd9);
      tick();
      check_span(4, vecs[0].exp_seg);
      @(negedge clk);
      sec = 6'd58;
      check_span(19, vecs[0].exp_seg);
      check_span(24, {7'h3F, 7'h6F, 7'h06, 7'h5B, 7'h6D, 7'h7F});

      // Input change on the frame-start cycle is shown in that frame.
      do_reset(6'd37, 6'd12, 6'd9);
      tick();
      check_span(22, vecs[0].exp_seg);
      @(negedge clk);
      sec = 6'd0; min = 6'd59; hour = 6'd0;
      check_span(1, vecs[0].exp_seg);
      check_span(24, vecs[1].exp_seg);

      // Reset mid-frame at idx = 3, cnt = 2 (state after edge 14).
      do_reset(6'd37, 6'd12, 6'd9);
      tick();
      check_span(13, vecs[0].exp_seg);
      @(negedge clk);
      rst_n = 1'b0;
      tick();
      chk("midrst_com", int'(com), 0);
      chk("midrst_seg", int'(seg), 0);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      tick();
      check_span(23, vecs[0].exp_seg);

      // Frame timing: edges between successive rises of com = 000001.
      first_edge = -1;
      second_edge = -1;
      prev_com = com;
      for (int i = 0; i < 200 && second_edge < 0; i++) begin
         tick();
         if (com == 6'b000001 && prev_com != 6'b000001) begin
            if (first_edge < 0) first_edge = k;
            else second_edge = k;
         end
         prev_com = com;
      end
      if (second_edge < 0) begin
         chk("frame_timeout", 0, 1);
      end else begin
         chk("frame_len", second_edge - first_edge, 6 * DIV);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
